// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU job sequencer.
//   - ALU op codes (add/sub/mul/div)
//   - Sequencer FSM state encoding
//   - word_count(): number of operand words an op pushes onto the ALU inbus
//   - sign_ext():   widen an 8-bit add/sub result to the 16-bit response
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int ALU_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_LOAD  = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_ABORT = 3'd4;
    localparam state_t ST_RESP  = 3'd5;

    // Divide carries a 16-bit dividend, so it needs one extra operand word.
    function automatic logic [1:0] word_count(input logic [1:0] op);
        return (op == OP_DIV) ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [2*ALU_W-1:0] sign_ext(input logic [ALU_W-1:0] v);
        return {{ALU_W{v[ALU_W-1]}}, v};
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin arbiter. Grant is combinational and only issued while
// enable is high; when both requesters are active the one that was not
// granted last wins.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset (last_grant resets to 1)
//   req[1:0]   request vector
//   enable     arbitration allowed this cycle
//   grant[1:0] one-hot grant (zero when nothing granted)
//   last_grant index of the most recent grant
// ---------------------------------------------------------------------------
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic r_last;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = r_last ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= 1'b1;
        end else if (grant[0]) begin
            r_last <= 1'b0;
        end else if (grant[1]) begin
            r_last <= 1'b1;
        end
    end

    assign last_grant = r_last;

endmodule

// File: rtl/alu_job_sequencer.sv
// ---------------------------------------------------------------------------
// alu_job_sequencer
// Two-requester front end for the multi-cycle 8-bit ALU. Arbitrates between
// two job ports, runs the ALU handshake (BEGIN, operand words, wait for END,
// capture result words), returns a tagged 2*DATA_W response on a valid/ready
// port, and recovers a hung ALU with a timeout plus ALU reset pulse.
// Ports:
//   clk, reset               clock; asynchronous active-low reset
//   req{0,1}_valid/ready     job handshake (ready is combinational, 1 cycle)
//   req{0,1}_op/x/y          op code, first operand (div: 16-bit dividend), y
//   rsp_valid/ready          response handshake
//   rsp_id/data/timeout      requester index, result, aborted flag
//   alu_reset/begin/op_code  ALU control
//   alu_inbus/outbus/end     ALU data buses and completion strobe
//   busy                     sequencer not idle
// ---------------------------------------------------------------------------
module alu_job_sequencer
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DATA_W         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [1:0]            req0_op,
    input  logic [2*DATA_W-1:0]   req0_x,
    input  logic [DATA_W-1:0]     req0_y,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [1:0]            req1_op,
    input  logic [2*DATA_W-1:0]   req1_x,
    input  logic [DATA_W-1:0]     req1_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [2*DATA_W-1:0]   rsp_data,
    output logic                  rsp_timeout,
    output logic                  alu_reset,
    output logic                  alu_begin,
    output logic [1:0]            alu_op_code,
    output logic [DATA_W-1:0]     alu_inbus,
    input  logic [DATA_W-1:0]     alu_outbus,
    input  logic                  alu_end,
    output logic                  busy
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_op;
    logic [2*DATA_W-1:0]   r_x;
    logic [DATA_W-1:0]     r_y;
    logic [1:0]            r_wcnt;
    logic [7:0]            r_tcnt;
    logic [DATA_W-1:0]     r_prev;
    logic [2*DATA_W-1:0]   r_rsp_data;
    logic                  r_rsp_timeout;
    logic                  r_alu_rst_hold;

    logic [1:0]            w_grant;
    logic                  w_grant_any;
    logic                  w_last_grant;
    logic                  w_arb_enable;
    logic [1:0]            w_sel_op;
    logic [2*DATA_W-1:0]   w_sel_x;
    logic [DATA_W-1:0]     w_sel_y;
    logic [1:0]            w_word_idx;
    logic [DATA_W-1:0]     w_word;
    logic                  w_last_word;
    logic [2*DATA_W-1:0]   w_result;

    // -----------------------------------------------------------------------
    // Arbitration. No grant while busy, and none while the ALU is still held
    // in reset right after release, so the first BEGIN always reaches a live
    // ALU.
    // -----------------------------------------------------------------------
    assign w_arb_enable = (r_state == ST_IDLE) && !r_alu_rst_hold;

    rr_arbiter_2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        ({req1_valid, req0_valid}),
        .enable     (w_arb_enable),
        .grant      (w_grant),
        .last_grant (w_last_grant)
    );

    assign w_grant_any = |w_grant;
    assign req0_ready  = w_grant[0];
    assign req1_ready  = w_grant[1];

    assign w_sel_op = w_grant[1] ? req1_op : req0_op;
    assign w_sel_x  = w_grant[1] ? req1_x  : req0_x;
    assign w_sel_y  = w_grant[1] ? req1_y  : req0_y;

    // -----------------------------------------------------------------------
    // Operand word selection. Non-div ops skip the high dividend byte by
    // starting one slot later in the x_hi, x_lo, y sequence.
    // -----------------------------------------------------------------------
    always_comb begin
        w_word_idx = (r_op == OP_DIV) ? r_wcnt : r_wcnt + 2'd1;
        case (w_word_idx)
            2'd0:    w_word = r_x[2*DATA_W-1:DATA_W];
            2'd1:    w_word = r_x[DATA_W-1:0];
            default: w_word = r_y;
        endcase
    end

    assign w_last_word = (r_wcnt == (word_count(r_op) - 2'd1));

    // Add/sub return one signed word; mul/div return the word seen the cycle
    // before END as the high half.
    assign w_result = ((r_op == OP_ADD) || (r_op == OP_SUB))
                    ? {{DATA_W{alu_outbus[DATA_W-1]}}, alu_outbus}
                    : {r_prev, alu_outbus};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                // END before the operands are in is a protocol error.
                w_state_next = alu_end ? ST_ABORT : ST_LOAD;
            end
            ST_LOAD: begin
                if (alu_end) begin
                    w_state_next = ST_ABORT;
                end else if (w_last_word) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (alu_end) begin
                    w_state_next = ST_RESP;
                end else if (r_tcnt == TMO_LAST) begin
                    w_state_next = ST_ABORT;
                end
            end
            ST_ABORT: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_op           <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_wcnt         <= '0;
            r_tcnt         <= '0;
            r_prev         <= '0;
            r_rsp_data     <= '0;
            r_rsp_timeout  <= 1'b0;
            r_alu_rst_hold <= 1'b1;
        end else begin
            r_state        <= w_state_next;
            r_alu_rst_hold <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_op          <= w_sel_op;
                        r_x           <= w_sel_x;
                        r_y           <= w_sel_y;
                        r_rsp_data    <= '0;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                ST_START: begin
                    r_wcnt <= '0;
                end
                ST_LOAD: begin
                    r_wcnt <= r_wcnt + 2'd1;
                    // Leaves the timeout counter at zero on entry to WAIT.
                    r_tcnt <= '0;
                end
                ST_WAIT: begin
                    r_prev <= alu_outbus;
                    r_tcnt <= r_tcnt + 8'd1;
                    if (alu_end) begin
                        r_rsp_data <= w_result;
                    end
                end
                default: begin
                end
            endcase
            if (w_state_next == ST_ABORT) begin
                r_rsp_timeout <= 1'b1;
                r_rsp_data    <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy        = (r_state != ST_IDLE);
    assign alu_begin   = (r_state == ST_START);
    assign alu_op_code = ((r_state == ST_START) || (r_state == ST_LOAD) ||
                          (r_state == ST_WAIT)) ? r_op : 2'b00;
    assign alu_inbus   = (r_state == ST_LOAD) ? w_word : '0;
    // Held high through reset and the first cycle after release, plus the
    // single ABORT cycle.
    assign alu_reset   = r_alu_rst_hold || (r_state == ST_ABORT);

    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;
    // The arbiter's last_grant is the id of the job in flight, since no new
    // grant happens until the sequencer is idle again.
    assign rsp_id      = (r_state == ST_RESP) ? w_last_grant : 1'b0;

endmodule
